// File: rtl/mem_arb_pkg.sv
// Shared constants and port-index type for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_t;

   // Opposite port index; used by the round-robin decision.
   function automatic port_t other_port(input port_t p);
      return (p == PORT0) ? PORT1 : PORT0;
   endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Combinational winner selection from the two request bits, the
// last-granted pointer and the arbitration mode (fixed or round-robin).
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic  req0,
   input  logic  req1,
   input  port_t last,
   input  logic  rr_en,
   output logic  valid_c,
   output port_t winner_c
);

   always_comb begin
      valid_c  = req0 | req1;
      winner_c = PORT0;
      if (req0 && req1) begin
         // Under contention only round-robin mode looks at the pointer.
         winner_c = rr_en ? other_port(last) : PORT0;
      end else if (req1) begin
         winner_c = PORT1;
      end
   end

endmodule : mem_arb_pick

// File: rtl/mem_arb.sv
// Two-port single-memory arbiter with same-cycle grant and one-cycle read return.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority (port 0).
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,

   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   port_t             last_q;
   port_t             owner_q;
   logic              pend_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] p0_rdata_q;
   logic [DATA_W-1:0] p1_rdata_q;

   logic              pick_valid_c;
   port_t             pick_port_c;
   logic              sel_we_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              rd_start_c;

   // Requests are masked while reset is held so no grant escapes.
   mem_arb_pick u_pick (
      .req0     (p0_req & rst_n),
      .req1     (p1_req & rst_n),
      .last     (last_q),
      .rr_en    (RR_EN),
      .valid_c  (pick_valid_c),
      .winner_c (pick_port_c)
   );

   // Grant decode and memory-side mux; idle cycles replay the last address/data.
   always_comb begin
      p0_gnt      = 1'b0;
      p1_gnt      = 1'b0;
      sel_we_c    = p0_we;
      sel_addr_c  = p0_addr;
      sel_wdata_c = p0_wdata;
      if (pick_port_c == PORT1) begin
         sel_we_c    = p1_we;
         sel_addr_c  = p1_addr;
         sel_wdata_c = p1_wdata;
      end
      if (pick_valid_c) begin
         p0_gnt = (pick_port_c == PORT0);
         p1_gnt = (pick_port_c == PORT1);
      end
      rd_start_c = pick_valid_c & ~sel_we_c;
      mem_we     = pick_valid_c & sel_we_c;
      mem_addr   = pick_valid_c ? sel_addr_c  : addr_q;
      mem_wdata  = pick_valid_c ? sel_wdata_c : wdata_q;
   end

   // Response steering: memory data is passed through in the response cycle
   // and captured so the port's rdata holds afterwards.
   always_comb begin
      p0_rvalid = pend_q & (owner_q == PORT0);
      p1_rvalid = pend_q & (owner_q == PORT1);
      p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_q;
      p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_q;
   end

   // Pointer, owner, outstanding-read flag and held bus values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= PORT1;
         owner_q    <= PORT0;
         pend_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         pend_q <= rd_start_c;
         if (pick_valid_c) begin
            last_q  <= pick_port_c;
            addr_q  <= sel_addr_c;
            wdata_q <= sel_wdata_c;
         end
         if (rd_start_c) begin
            owner_q <= pick_port_c;
         end
         if (p0_rvalid) begin
            p0_rdata_q <= mem_rdata;
         end
         if (p1_rvalid) begin
            p1_rdata_q <= mem_rdata;
         end
      end
   end

endmodule : mem_arb

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios then random traffic
// compared against a transaction-level model of grants, memory and responses.
module tb_mem_arb;

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 64;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous memory: read-before-write, data one cycle after address.
   logic [DW-1:0] mem_arr [DEPTH];
   always @(posedge clk) begin
      mem_rdata <= mem_arr[mem_addr];
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
   end

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            ptr;
   bit            pend;
   int            pend_port;
   logic [DW-1:0] pend_data;
   logic [DW-1:0] rhold [2];
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;
   int            last_g;
   int            checks;
   int            errors;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: check outputs against the model, then advance both.
   task automatic cycle();
      int            g;
      bit            rv0, rv1, gwe;
      logic [AW-1:0] ga;
      logic [DW-1:0] gw;
      #1;
      if (!rst_n) begin
         pend       = 1'b0;
         ptr        = 1;
         rhold[0]   = '0;
         rhold[1]   = '0;
         last_addr  = '0;
         last_wdata = '0;
      end
      g = -1;
      if (rst_n) begin
         if (p0_req && p1_req) g = RR ? ((ptr == 0) ? 1 : 0) : 0;
         else if (p0_req)      g = 0;
         else if (p1_req)      g = 1;
      end
      gwe = (g == 0) ? p0_we    : p1_we;
      ga  = (g == 0) ? p0_addr  : p1_addr;
      gw  = (g == 0) ? p0_wdata : p1_wdata;
      rv0 = pend && (pend_port == 0);
      rv1 = pend && (pend_port == 1);
      check("p0_gnt",    64'(p0_gnt),    64'(g == 0));
      check("p1_gnt",    64'(p1_gnt),    64'(g == 1));
      check("mem_we",    64'(mem_we),    64'((g >= 0) && gwe));
      check("mem_addr",  64'(mem_addr),  64'((g >= 0) ? ga : last_addr));
      check("mem_wdata", 64'(mem_wdata), 64'((g >= 0) ? gw : last_wdata));
      check("p0_rvalid", 64'(p0_rvalid), 64'(rv0));
      check("p1_rvalid", 64'(p1_rvalid), 64'(rv1));
      check("p0_rdata",  64'(p0_rdata),  64'(rv0 ? pend_data : rhold[0]));
      check("p1_rdata",  64'(p1_rdata),  64'(rv1 ? pend_data : rhold[1]));
      if (rv0) rhold[0] = pend_data;
      if (rv1) rhold[1] = pend_data;
      pend = 1'b0;
      if (g >= 0) begin
         ptr        = g;
         last_addr  = ga;
         last_wdata = gw;
         if (gwe) ref_mem[ga] = gw;
         else begin
            pend      = 1'b1;
            pend_port = g;
            pend_data = ref_mem[ga];
         end
      end
      last_g = g;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0; errors = 0;
      ptr = 1; pend = 1'b0; pend_port = 0; pend_data = '0;
      rhold[0] = '0; rhold[1] = '0; last_addr = '0; last_wdata = '0; last_g = -1;
      mem_rdata = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[5] = 32'hDEADBEEF;
      ref_mem[5] = 32'hDEADBEEF;

      // Reset held with both ports requesting, then release.
      rst_n = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd1; p0_wdata = '0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 6'd2; p1_wdata = '0;
      @(negedge clk);
      cycle(); cycle();
      rst_n = 1'b1;
      cycle();
      check("first_grant_p0", 64'(last_g), 64'(0));
      p0_req = 1'b0; p1_req = 1'b0;
      cycle();

      // Single p1 read of word 5.
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 6'd5;
      cycle();
      p1_req = 1'b0;
      #1;
      check("p1_read_data", 64'(p1_rdata), 64'(32'hDEADBEEF));
      cycle();

      // Continuous contention for 4 cycles, then p0 drops.
      p0_req = 1'b1; p0_addr = 6'd10;
      p1_req = 1'b1; p1_addr = 6'd20;
      repeat (4) cycle();
      p0_req = 1'b0;
      cycle();
      p1_req = 1'b0;
      cycle();

      // p1 writes top address, p0 reads it next cycle.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 6'd63; p1_wdata = 32'h12345678;
      cycle();
      p1_req = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd63;
      cycle();
      p0_req = 1'b0;
      #1;
      check("wr_then_rd", 64'(p0_rdata), 64'(32'h12345678));
      cycle();

      // Read then write to the same word: read sees the old value.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd7;
      cycle();
      p0_req = 1'b0;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 6'd7; p1_wdata = 32'hA5A5_0F0F;
      cycle();
      p1_req = 1'b0;
      cycle();

      // Reset in the cycle after a p0 read grant: response is dropped.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd3;
      cycle();
      p0_req = 1'b0;
      rst_n = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1;
      cycle(); cycle();

      // Random traffic; each requester holds its transaction until granted.
      for (int n = 0; n < 400; n++) begin
         if (!p0_req || last_g == 0) begin
            p0_req   = ($urandom_range(0, 3) != 0);
            p0_we    = 1'($urandom_range(0, 1));
            p0_addr  = AW'($urandom_range(0, DEPTH - 1));
            p0_wdata = $urandom;
         end
         if (!p1_req || last_g == 1) begin
            p1_req   = ($urandom_range(0, 3) != 0);
            p1_we    = 1'($urandom_range(0, 1));
            p1_addr  = AW'($urandom_range(0, DEPTH - 1));
            p1_wdata = $urandom;
         end
         cycle();
      end
      p0_req = 1'b0; p1_req = 1'b0;
      cycle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_arb
